// File: rtl/uart_telemetria_tx_if.sv
// rtl/uart_telemetria_tx_if.sv - status word request and serial/status outputs of the telemetry UART
interface uart_telemetria_tx_if #(
  parameter int DATA_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  wr;
  logic                  s_out;
  logic                  ocupado;
  logic                  fifo_cheia;
  logic                  descartado;

  modport master (
    output i_data, wr,
    input  s_out, ocupado, fifo_cheia, descartado
  );

  modport slave (
    input  i_data, wr,
    output s_out, ocupado, fifo_cheia, descartado
  );
endinterface

// File: rtl/uart_telemetria_tx.sv
// rtl/uart_telemetria_tx.sv - buffered, framed UART transmitter for the game status word
module uart_telemetria_tx #(
  parameter int         DATA_WIDTH = 14,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CLK_DIV    = 434,
  parameter int         PARITY     = 0,
  parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
  input  logic               clock,
  input  logic               reset,
  uart_telemetria_tx_if.slave bus
);
  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int FW     = 8 * NBYTES;
  localparam int CW     = $clog2(CLK_DIV);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(NBYTES + 2);
  localparam logic [CW-1:0] TICK_MAX = CW'(CLK_DIV - 1);
  localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);

  typedef enum logic [2:0] {OCIOSO, CARREGA, START, DADOS, PARIDADE, STOP} state_t;
  state_t state, state_n;

  logic                  wr_q;
  logic                  push, pop, accept;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [PW:0]           count, count_n;
  logic [FW-1:0]         frame;
  logic [IW-1:0]         idx;
  logic [7:0]            cur, shreg, chk, sel_byte;
  logic [2:0]            bit_idx;
  logic [CW-1:0]         cnt;
  logic                  tick, par_bit, s_out_n;
  logic                  s_out_r, ocupado_r, fifo_cheia_r;

  // Only a rising edge of the level request captures a word.
  assign push    = bus.wr & ~wr_q;
  assign pop     = (state == OCIOSO) && (count != '0);
  assign accept  = push && ((count < FULL) || pop);
  assign count_n = count + (PW + 1)'(accept) - (PW + 1)'(pop);
  assign tick    = (cnt == TICK_MAX);
  assign par_bit = (PARITY == 2) ? ~^cur : ^cur;

  assign bus.descartado = push && !accept;
  assign bus.s_out      = s_out_r;
  assign bus.ocupado    = ocupado_r;
  assign bus.fifo_cheia = fifo_cheia_r;

  // Word storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (accept) mem[wptr] <= bus.i_data;
  end

  // Edge detector, FIFO bookkeeping and registered status/line outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q         <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      s_out_r      <= 1'b1;
      ocupado_r    <= 1'b0;
      fifo_cheia_r <= 1'b0;
    end else begin
      wr_q         <= bus.wr;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      count        <= count_n;
      s_out_r      <= s_out_n;
      ocupado_r    <= (state_n != OCIOSO) || (count_n != '0);
      fifo_cheia_r <= (count_n == FULL);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= state_n;
  end

  // Next-state logic and the line level for the current bit.
  always_comb begin
    state_n = state;
    s_out_n = 1'b1;
    case (state)
      OCIOSO:   if (count != '0) state_n = CARREGA;
      CARREGA:  state_n = START;
      START: begin
        s_out_n = 1'b0;
        if (tick) state_n = DADOS;
      end
      DADOS: begin
        s_out_n = shreg[0];
        if (tick && bit_idx == 3'd7) state_n = (PARITY != 0) ? PARIDADE : STOP;
      end
      PARIDADE: begin
        s_out_n = par_bit;
        if (tick) state_n = STOP;
      end
      STOP:     if (tick) state_n = (idx == LAST_IDX) ? OCIOSO : CARREGA;
      default:  state_n = OCIOSO;
    endcase
  end

  // Byte for the current frame position: sync, data (LSB first) or checksum.
  always_comb begin
    sel_byte = SYNC_BYTE;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i + 1)) sel_byte = frame[8*i +: 8];
    end
    if (idx == LAST_IDX) sel_byte = chk;
  end

  // Frame datapath: bit timer, shift register, byte index and checksum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame   <= '0;
      idx     <= '0;
      cur     <= '0;
      shreg   <= '0;
      chk     <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else begin
      cnt <= (state_n != state || tick) ? '0 : cnt + 1'b1;
      case (state)
        OCIOSO: begin
          if (pop) begin
            frame <= FW'(mem[rptr]);
            idx   <= '0;
            chk   <= '0;
          end
        end
        CARREGA: begin
          cur     <= sel_byte;
          shreg   <= sel_byte;
          bit_idx <= '0;
        end
        DADOS: begin
          if (tick) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (idx != '0 && idx != LAST_IDX) chk <= chk + cur;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/uart_telemetria_tx.md
# uart_telemetria_tx

Parametrised UART telemetry transmitter for the game status word. It captures a `DATA_WIDTH`-bit word on each rising edge of `wr` and queues it in a small FIFO. Each queued word goes out as a framed packet: sync byte, data bytes LSB-first, then a checksum. It replaces the fixed 14-bit direct UART hookup at the top level, adding buffering, edge-qualified capture, configurable parity and frame integrity checking.

## Interface
- `DATA_WIDTH`, default 14: width of the status word. `NBYTES = ceil(DATA_WIDTH/8)`.
- `FIFO_DEPTH`, default 4: number of queued words. Must be a power of 2, ≥2.
- `CLK_DIV`, default 434: clock cycles per UART bit. Must be ≥2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `SYNC_BYTE`, default 8'hAA: first byte of every frame.
- `clock` in 1: single system clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `i_data` in DATA_WIDTH: status word, sampled in the cycle `wr` rises.
- `wr` in 1: level request. Only a 0→1 transition captures a word.
- `s_out` out 1: serial line, idle high.
- `ocupado` out 1: high while the FSM is not in OCIOSO or the FIFO is non-empty.
- `fifo_cheia` out 1: FIFO holds `FIFO_DEPTH` words.
- `descartado` out 1: one-cycle pulse when a captured word is dropped because the FIFO is full.

## Operation
- Edge detect: `wr_q` is registered. `push = wr & ~wr_q`. `wr_q` resets to 0, so `wr` high out of reset counts as an edge on the first cycle.
- FIFO: circular buffer with separate read and write pointers plus a count.
  - Push is accepted if count < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the word is discarded, `descartado` = 1 for that cycle, and the FIFO is unchanged.
- Frame: `NBYTES + 2` bytes.
  - Byte 0: `SYNC_BYTE`.
  - Bytes 1..NBYTES: `i_data` zero-padded to `8*NBYTES`, least-significant byte first.
  - Final byte: checksum = sum of the data bytes mod 256. The sync byte is not included.
- Character: start bit 0, 8 data bits LSB-first, parity bit if `PARITY` ≠ 0, stop bit 1.
  - Even parity makes the total number of ones in data + parity even. Odd parity makes it odd.
- FSM states:
  - OCIOSO: `s_out` = 1. If the FIFO is non-empty, pop into the frame register, clear the checksum and byte index, go to CARREGA.
  - CARREGA: select byte[index] (sync, data or checksum) into the shift register, go to START.
  - START: `s_out` = 0 for `CLK_DIV` cycles, go to DADOS.
  - DADOS: shift out 8 bits, `CLK_DIV` cycles each, go to PARIDADE if parity is enabled, else STOP.
  - PARIDADE: `s_out` = parity bit for `CLK_DIV` cycles, go to STOP.
  - STOP: `s_out` = 1 for `CLK_DIV` cycles. Add the byte to the checksum if it was a data byte. If index = `NBYTES+1`, go to OCIOSO; else increment index and go to CARREGA.
- Frames are sent back-to-back with no idle gap beyond the CARREGA and OCIOSO cycles.
- Bit counter (`$clog2(CLK_DIV)` bits) reloads on every state entry. The state advances when the counter reaches `CLK_DIV-1`.
- Reset mid-frame: the frame is aborted, `s_out` goes high immediately, the FIFO empties, and nothing resumes.

## Timing
- Reset values: `s_out`=1, `ocupado`=0, `fifo_cheia`=0, `descartado`=0, FSM=OCIOSO, FIFO empty.
- `s_out` is driven from a register; it has no combinational path from inputs.
- Latency, with the FIFO empty and the FSM idle:
  - Edge k: `wr` is seen at 1 with `wr_q` = 0; the word is written.
  - Edge k+1: the FSM pops it.
  - Edge k+2: CARREGA.
  - Edge k+3: `s_out` falls for the start bit.
- Character length: `(10 + (PARITY≠0)) * CLK_DIV` cycles, plus 1 CARREGA cycle.
- Frame length: `(NBYTES+2)` × (character length) + 1 OCIOSO cycle.
- `fifo_cheia` and `ocupado` are registered. They reflect the FIFO and FSM state after each edge.
- `descartado` is asserted in the same cycle as the dropped push. It is never high for two consecutive cycles from a single edge.

## Test plan
- Single word, defaults except `CLK_DIV`=4, `PARITY`=0. Drive `i_data`=14'h2A5C with a one-cycle `wr` pulse. Required: UART decode AA,5C,2A,86; `s_out` low 3 cycles after the `wr` edge; `ocupado` falls after 4×(40+1)+1 cycles.
- Level `wr`: hold `wr`=1 for 200 cycles. Required: exactly one frame; no `descartado`.
- Overflow with `FIFO_DEPTH`=4: six `wr` pulses every 2 cycles while the first frame is sending. Required: words 1–5 transmitted in order; `fifo_cheia`=1 after pulse 5; `descartado` pulses once, on pulse 6.
- Parity: `PARITY`=1 with `i_data`=14'h0001. Required: parity bits 0 (AA), 1 (01), 0 (00), 1 (01). Repeat with `PARITY`=2: every parity bit inverted.
- Width: `DATA_WIDTH`=20 with `i_data`=20'hF1234. Required: AA,34,12,0F,55.
- Reset mid-frame: assert `reset` during a data bit of byte 2. Required: `s_out`=1 within the reset cycle; `ocupado`=0; no further frame after release until a new `wr` edge.
